// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query and MD control bundle between the pipeline and the hazard scoreboard.
// The pipeline drives the master side; the scoreboard answers on the slave side.
interface hazard_scoreboard_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic [4:0] D_A3;
  logic       D_we;
  logic [1:0] D_tnew;
  logic       D_is_md;
  logic       E_md_start;
  logic       E_md_div;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_A3, D_we, D_tnew, D_is_md,
           E_md_start, E_md_div, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_A3, D_we, D_tnew, D_is_md,
           E_md_start, E_md_div, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight GRF writes through E/M/W, produces the D-stage stall and
// forwarding selects, and owns the multiply/divide busy counter.
module hazard_scoreboard #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   bus
);
  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [4:0] e_a3_reg, m_a3_reg, w_a3_reg;
  logic       e_we_reg, m_we_reg, w_we_reg;
  logic [1:0] e_tnew_reg, m_tnew_reg;
  logic [4:0] e_a3_next;
  logic       e_we_next;
  logic [1:0] e_tnew_next, m_tnew_next;
  logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;

  logic [1:0][4:0] op_id;
  logic [1:0][1:0] op_tuse;
  logic [1:0][1:0] op_sel;
  logic [1:0]      op_stall;
  logic            md_stall;

  assign op_id   = {bus.D_rt, bus.D_rs};
  assign op_tuse = {bus.D_tuse_rt, bus.D_tuse_rs};

  // Youngest match wins; W results are always available.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic       hit_e, hit_m, hit_w, hit_any;
      logic [1:0] tnew_y, idx_y;
      assign hit_e   = e_we_reg && (e_a3_reg == op_id[gi]) && (op_id[gi] != 5'd0);
      assign hit_m   = m_we_reg && (m_a3_reg == op_id[gi]) && (op_id[gi] != 5'd0);
      assign hit_w   = w_we_reg && (w_a3_reg == op_id[gi]) && (op_id[gi] != 5'd0);
      assign hit_any = hit_e || hit_m || hit_w;
      assign tnew_y  = hit_e ? e_tnew_reg : (hit_m ? m_tnew_reg : 2'd0);
      assign idx_y   = hit_e ? 2'd1 : (hit_m ? 2'd2 : 2'd3);
      assign op_sel[gi]   = (hit_any && (tnew_y == 2'd0)) ? idx_y : 2'd0;
      assign op_stall[gi] = hit_any && (tnew_y > op_tuse[gi]);
    end
  endgenerate

  assign bus.md_busy    = bus.E_md_start || (md_cnt_reg != '0);
  assign md_stall       = bus.D_is_md && bus.md_busy;
  assign bus.stall      = op_stall[0] || op_stall[1] || md_stall;
  assign bus.fwd_rs_sel = op_sel[0];
  assign bus.fwd_rt_sel = op_sel[1];

  always_comb begin
    e_a3_next   = bus.D_A3;
    e_we_next   = bus.D_we;
    e_tnew_next = bus.D_tnew;
    if (bus.flush || bus.stall) begin
      e_a3_next   = 5'd0;
      e_we_next   = 1'b0;
      e_tnew_next = 2'd0;
    end
    m_tnew_next = (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
    md_cnt_next = (md_cnt_reg == '0) ? '0 : md_cnt_reg - 1'b1;
    if (bus.E_md_start)
      md_cnt_next = bus.E_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_reg   <= 5'd0;
      e_we_reg   <= 1'b0;
      e_tnew_reg <= 2'd0;
      m_a3_reg   <= 5'd0;
      m_we_reg   <= 1'b0;
      m_tnew_reg <= 2'd0;
      w_a3_reg   <= 5'd0;
      w_we_reg   <= 1'b0;
      md_cnt_reg <= '0;
    end else begin
      w_a3_reg   <= m_a3_reg;
      w_we_reg   <= m_we_reg;
      e_a3_reg   <= e_a3_next;
      e_we_reg   <= e_we_next;
      e_tnew_reg <= e_tnew_next;
      md_cnt_reg <= md_cnt_next;
      // A flush kills the E instruction on its way into M.
      if (bus.flush) begin
        m_a3_reg   <= 5'd0;
        m_we_reg   <= 1'b0;
        m_tnew_reg <= 2'd0;
      end else begin
        m_a3_reg   <= e_a3_reg;
        m_we_reg   <= e_we_reg;
        m_tnew_reg <= m_tnew_next;
      end
    end
  end
endmodule
